// File: rtl/chef_move_ctrl.sv
// Per-frame chef movement sequencer: key + map flags -> registered walk/climb/dir/anim.
// Define CHEF_TURN_BUFFER_EN to compile in the 1-entry perpendicular turn buffer.
module chef_move_ctrl #(
  parameter int BUF_FRAMES  = 16,
  parameter int ANIM_PERIOD = 8
) (
  input  logic       Reset,
  input  logic       frame_clk,
  input  logic [7:0] keycode,
  input  logic       freeze,
  input  logic       at_floor,
  input  logic       at_ladder,
  input  logic       ladder_up,
  input  logic       ladder_down,
  input  logic       wall_left,
  input  logic       wall_right,
  output logic       walk,
  output logic       climb,
  output logic [1:0] dir,
  output logic [1:0] anim,
  output logic [1:0] state
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_WALK   = 2'd1;
  localparam logic [1:0] S_CLIMB  = 2'd2;
  localparam logic [1:0] S_FROZEN = 2'd3;

  localparam logic [1:0] DIR_L = 2'd0;
  localparam logic [1:0] DIR_R = 2'd1;
  localparam logic [1:0] DIR_U = 2'd2;
  localparam logic [1:0] DIR_D = 2'd3;

  logic [1:0] state_q, state_d;
  logic [1:0] dir_q, dir_d;
  logic [1:0] anim_q, anim_d;
  logic [7:0] animCnt_q, animCnt_d;
  logic       walk_q, climb_q;

  logic       reqValid;
  logic [1:0] reqDir;
  logic [3:0] legalVec;
  logic [3:0] contOk;
  logic       liveLegal;
  logic       moving;
  logic       bufHit;
  logic [1:0] bufDir;

  always_comb begin
    reqValid = 1'b1;
    reqDir   = DIR_R;
    case (keycode)
      8'h04:   reqDir = DIR_L;
      8'h07:   reqDir = DIR_R;
      8'h1A:   reqDir = DIR_U;
      8'h16:   reqDir = DIR_D;
      default: reqValid = 1'b0;
    endcase
  end

  // Both vectors are indexed by direction code: a fresh start vs. carrying on in that direction.
  assign legalVec  = {at_ladder & ladder_down, at_ladder & ladder_up,
                      at_floor & ~wall_right, at_floor & ~wall_left};
  assign contOk    = {ladder_down, ladder_up, ~wall_right, ~wall_left};
  assign liveLegal = reqValid & legalVec[reqDir];
  assign moving    = (state_q == S_WALK) | (state_q == S_CLIMB);

`ifdef CHEF_TURN_BUFFER_EN
  logic       bufValid_q;
  logic [1:0] bufDir_q;
  logic [7:0] bufCnt_q;
  logic       loadBuf;

  assign bufHit  = bufValid_q & legalVec[bufDir_q];
  assign bufDir  = bufDir_q;
  assign loadBuf = reqValid & ~liveLegal & moving & (reqDir[1] ^ (state_q == S_CLIMB));

  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      bufValid_q <= 1'b0;
      bufDir_q   <= DIR_R;
      bufCnt_q   <= 8'd0;
    end else if (freeze | liveLegal | bufHit) begin
      bufValid_q <= 1'b0;
    end else if (loadBuf) begin
      bufValid_q <= 1'b1;
      bufDir_q   <= reqDir;
      bufCnt_q   <= 8'(BUF_FRAMES);
    end else if (bufValid_q) begin
      bufCnt_q <= bufCnt_q - 8'd1;
      if (bufCnt_q == 8'd1) bufValid_q <= 1'b0;
    end
  end
`else
  assign bufHit = 1'b0;
  assign bufDir = DIR_R;
`endif

  always_comb begin
    state_d = state_q;
    dir_d   = dir_q;
    if (freeze) begin
      state_d = S_FROZEN;
    end else if (state_q == S_FROZEN) begin
      state_d = S_IDLE;
    end else if (liveLegal) begin
      state_d = reqDir[1] ? S_CLIMB : S_WALK;
      dir_d   = reqDir;
    end else if (bufHit) begin
      state_d = bufDir[1] ? S_CLIMB : S_WALK;
      dir_d   = bufDir;
    end else if (reqValid && moving) begin
      if (!contOk[dir_q]) state_d = S_IDLE;
    end else begin
      state_d = S_IDLE;
    end
  end

  // The counter advances on frames that end up moving, so the first walking frame already counts.
  always_comb begin
    animCnt_d = animCnt_q;
    anim_d    = anim_q;
    if (dir_d != dir_q) begin
      animCnt_d = 8'd0;
      anim_d    = 2'd0;
    end else if ((state_d == S_WALK) || (state_d == S_CLIMB)) begin
      if (animCnt_q == 8'(ANIM_PERIOD - 1)) begin
        animCnt_d = 8'd0;
        anim_d    = anim_q + 2'd1;
      end else begin
        animCnt_d = animCnt_q + 8'd1;
      end
    end
  end

  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      state_q   <= S_IDLE;
      dir_q     <= DIR_R;
      anim_q    <= 2'd0;
      animCnt_q <= 8'd0;
      walk_q    <= 1'b0;
      climb_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      dir_q     <= dir_d;
      anim_q    <= anim_d;
      animCnt_q <= animCnt_d;
      walk_q    <= (state_d == S_WALK);
      climb_q   <= (state_d == S_CLIMB);
    end
  end

  assign walk  = walk_q;
  assign climb = climb_q;
  assign dir   = dir_q;
  assign anim  = anim_q;
  assign state = state_q;

endmodule

// File: tb/tb_chef_move_ctrl.sv
// Scoreboard bench for chef_move_ctrl: directed scenarios then random frames against a rule model.
// Honours CHEF_TURN_BUFFER_EN so the model matches whichever build is compiled.
module tb_chef_move_ctrl;

  localparam int BUF_FRAMES  = 16;
  localparam int ANIM_PERIOD = 8;
`ifdef CHEF_TURN_BUFFER_EN
  localparam bit BufOn = 1'b1;
`else
  localparam bit BufOn = 1'b0;
`endif

  localparam int ST_IDLE   = 0;
  localparam int ST_WALK   = 1;
  localparam int ST_CLIMB  = 2;
  localparam int ST_FROZEN = 3;

  typedef struct packed {
    logic [1:0] state;
    logic       walk;
    logic       climb;
    logic [1:0] dir;
    logic [1:0] anim;
  } outs_t;

  logic       Reset;
  logic       frame_clk;
  logic [7:0] keycode;
  logic       freeze, at_floor, at_ladder, ladder_up, ladder_down, wall_left, wall_right;
  logic       walk, climb;
  logic [1:0] dir, anim, state;

  chef_move_ctrl #(.BUF_FRAMES(BUF_FRAMES), .ANIM_PERIOD(ANIM_PERIOD)) dut (
    .Reset(Reset), .frame_clk(frame_clk), .keycode(keycode), .freeze(freeze),
    .at_floor(at_floor), .at_ladder(at_ladder), .ladder_up(ladder_up),
    .ladder_down(ladder_down), .wall_left(wall_left), .wall_right(wall_right),
    .walk(walk), .climb(climb), .dir(dir), .anim(anim), .state(state)
  );

  initial frame_clk = 1'b0;
  always #5 frame_clk = ~frame_clk;

  int    checks = 0;
  int    errors = 0;
  outs_t expQ[$];
  string nameQ[$];
  string phase = "init";

  // Reference model: state, direction, moving frames since the last direction change, buffer entry.
  int mState, mDir, mMove, mFrame;
  bit mBufValid;
  int mBufDir, mBufFrame;

  function automatic int decodeKey(input logic [7:0] k);
    case (k)
      8'h04:   return 0;
      8'h07:   return 1;
      8'h1A:   return 2;
      8'h16:   return 3;
      default: return -1;
    endcase
  endfunction

  function automatic bit isLegal(input int d);
    case (d)
      0:       return at_floor && !wall_left;
      1:       return at_floor && !wall_right;
      2:       return at_ladder && ladder_up;
      default: return at_ladder && ladder_down;
    endcase
  endfunction

  function automatic bit canContinue(input int d);
    case (d)
      0:       return !wall_left;
      1:       return !wall_right;
      2:       return ladder_up;
      default: return ladder_down;
    endcase
  endfunction

  function automatic outs_t modelOuts();
    outs_t e;
    e.state = 2'(mState);
    e.walk  = (mState == ST_WALK);
    e.climb = (mState == ST_CLIMB);
    e.dir   = 2'(mDir);
    e.anim  = 2'((mMove / ANIM_PERIOD) % 4);
    return e;
  endfunction

  task automatic modelReset();
    mState    = ST_IDLE;
    mDir      = 1;
    mMove     = 0;
    mBufValid = 1'b0;
    mBufDir   = 0;
    mBufFrame = 0;
  endtask

  task automatic modelStep();
    int req, nState, nDir;
    bit bufReady;
    req      = decodeKey(keycode);
    nState   = mState;
    nDir     = mDir;
    bufReady = BufOn && mBufValid && (mFrame - mBufFrame <= BUF_FRAMES) && isLegal(mBufDir);
    if (freeze) begin
      nState    = ST_FROZEN;
      mBufValid = 1'b0;
    end else if (mState == ST_FROZEN) begin
      nState = ST_IDLE;
    end else if (req >= 0 && isLegal(req)) begin
      nState    = (req >= 2) ? ST_CLIMB : ST_WALK;
      nDir      = req;
      mBufValid = 1'b0;
    end else if (bufReady) begin
      nState    = (mBufDir >= 2) ? ST_CLIMB : ST_WALK;
      nDir      = mBufDir;
      mBufValid = 1'b0;
    end else if (req >= 0 && (mState == ST_WALK || mState == ST_CLIMB)) begin
      if (!canContinue(mDir)) nState = ST_IDLE;
      if (BufOn && ((mState == ST_WALK) == (req >= 2))) begin
        mBufValid = 1'b1;
        mBufDir   = req;
        mBufFrame = mFrame;
      end
    end else begin
      nState = ST_IDLE;
    end
    if (nDir != mDir) mMove = 0;
    else if (nState == ST_WALK || nState == ST_CLIMB) mMove++;
    mState = nState;
    mDir   = nDir;
    mFrame++;
    expQ.push_back(modelOuts());
    nameQ.push_back(phase);
  endtask

  task automatic checkOutput(input string name, input outs_t act, input outs_t exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s @%0t: got state=%0d walk=%0b climb=%0b dir=%0d anim=%0d, want state=%0d walk=%0b climb=%0b dir=%0d anim=%0d",
               name, $time, act.state, act.walk, act.climb, act.dir, act.anim,
               exp.state, exp.walk, exp.climb, exp.dir, exp.anim);
    end
  endtask

  // One frame: inputs change on the falling edge, the model predicts the next rising edge.
  task automatic applyStimulus(input logic [7:0] k, input logic fr, input logic fl,
                               input logic ld, input logic lu, input logic ldn,
                               input logic wl, input logic wr);
    @(negedge frame_clk);
    Reset       = 1'b0;
    keycode     = k;
    freeze      = fr;
    at_floor    = fl;
    at_ladder   = ld;
    ladder_up   = lu;
    ladder_down = ldn;
    wall_left   = wl;
    wall_right  = wr;
    modelStep();
  endtask

  task automatic asyncResetCheck();
    @(negedge frame_clk);
    #2;
    Reset = 1'b1;
    modelReset();
    #1;
    checkOutput("async_reset", {state, walk, climb, dir, anim}, modelOuts());
  endtask

  initial begin
    outs_t e;
    string n;
    forever begin
      @(posedge frame_clk);
      #1;
      if (expQ.size() > 0) begin
        e = expQ.pop_front();
        n = nameQ.pop_front();
        checkOutput(n, {state, walk, climb, dir, anim}, e);
      end
    end
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    Reset = 1'b1; keycode = 8'h00; freeze = 1'b0; at_floor = 1'b0; at_ladder = 1'b0;
    ladder_up = 1'b0; ladder_down = 1'b0; wall_left = 1'b0; wall_right = 1'b0;
    mFrame = 0;
    modelReset();
    #1;
    checkOutput("reset_state", {state, walk, climb, dir, anim}, modelOuts());
    repeat (2) @(posedge frame_clk);

    phase = "walk_right";
    repeat (16) applyStimulus(8'h07, 0, 1, 0, 0, 0, 0, 0);
    phase = "wall_stop";
    applyStimulus(8'h07, 0, 1, 0, 0, 0, 0, 1);

    phase = "held_up_ladder";
    repeat (2) applyStimulus(8'h07, 0, 1, 0, 0, 0, 0, 0);
    repeat (3) applyStimulus(8'h1A, 0, 1, 0, 0, 0, 0, 0);
    applyStimulus(8'h1A, 0, 1, 1, 1, 0, 0, 0);

    phase = "buffered_up";
    repeat (3) applyStimulus(8'h07, 0, 1, 0, 0, 0, 0, 0);
    applyStimulus(8'h1A, 0, 1, 0, 0, 0, 0, 0);
    applyStimulus(8'h00, 0, 1, 0, 0, 0, 0, 0);
    applyStimulus(8'h00, 0, 1, 1, 1, 0, 0, 0);

    phase = "buffer_last_frame";
    repeat (2) applyStimulus(8'h07, 0, 1, 0, 0, 0, 0, 0);
    applyStimulus(8'h1A, 0, 1, 0, 0, 0, 0, 0);
    repeat (15) applyStimulus(8'h00, 0, 1, 0, 0, 0, 0, 0);
    applyStimulus(8'h00, 0, 1, 1, 1, 0, 0, 0);

    phase = "buffer_expired";
    repeat (2) applyStimulus(8'h07, 0, 1, 0, 0, 0, 0, 0);
    applyStimulus(8'h1A, 0, 1, 0, 0, 0, 0, 0);
    repeat (16) applyStimulus(8'h00, 0, 1, 0, 0, 0, 0, 0);
    applyStimulus(8'h00, 0, 1, 1, 1, 0, 0, 0);

    phase = "freeze_wins";
    applyStimulus(8'h04, 1, 1, 0, 0, 0, 0, 0);
    applyStimulus(8'h04, 1, 1, 0, 0, 0, 0, 0);
    applyStimulus(8'h04, 0, 1, 0, 0, 0, 0, 0);
    applyStimulus(8'h04, 0, 1, 0, 0, 0, 0, 0);

    phase = "turn_clears_anim";
    repeat (10) applyStimulus(8'h04, 0, 1, 0, 0, 0, 0, 0);
    applyStimulus(8'h1A, 0, 1, 1, 1, 0, 1, 0);
    repeat (3) applyStimulus(8'h16, 0, 0, 1, 1, 1, 0, 0);
    applyStimulus(8'h16, 0, 0, 1, 1, 0, 0, 0);

    phase = "pre_async_reset";
    repeat (3) applyStimulus(8'h07, 0, 1, 0, 0, 0, 0, 0);
    asyncResetCheck();
    phase = "after_reset";
    applyStimulus(8'h07, 0, 1, 0, 0, 0, 0, 0);

    phase = "random";
    for (int i = 0; i < 600; i++) begin
      logic [7:0] k;
      int sel;
      sel = $urandom_range(0, 9);
      case (sel)
        0, 1:    k = 8'h04;
        2, 3:    k = 8'h07;
        4, 5:    k = 8'h1A;
        6, 7:    k = 8'h16;
        8:       k = 8'($urandom_range(0, 255));
        default: k = 8'h00;
      endcase
      applyStimulus(k, ($urandom_range(0, 29) == 0), ($urandom_range(0, 3) != 0),
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0),
                    ($urandom_range(0, 3) == 0));
    end

    repeat (3) @(posedge frame_clk);
    #2;
    checks++;
    if (expQ.size() != 0) begin
      errors++;
      $display("[TB] FAIL drain: %0d expected frames left unchecked, want 0", expQ.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/chef_move_ctrl.md
# chef_move_ctrl

Per-frame movement sequencer for the chef sprite. It converts the raw USB keycode and the level-map status flags at the chef's current position into registered `walk`/`climb` enables, a direction code and an animation frame index. Those outputs drive the chef position block and the sprite renderer. It enforces floor/ladder alignment and can buffer a turn request until the chef reaches a ladder or floor.

## Interface
- `BUF_FRAMES`, 16: turn-buffer lifetime in frames (1..255).
- `ANIM_PERIOD`, 8: frames per animation step (2..255).
- `Reset` in 1: asynchronous, active-high.
- `frame_clk` in 1: clock, one edge per video frame.
- `keycode` in 8: 0x04 A=left, 0x07 D=right, 0x16 S=down, 0x1A W=up; anything else = none.
- `freeze` in 1: level-end or death; forces the block to stop.
- `at_floor` in 1: chef Y is on a floor row.
- `at_ladder` in 1: chef X is on a ladder column.
- `ladder_up` / `ladder_down` in 1: a ladder continues above / below the current cell.
- `wall_left` / `wall_right` in 1: the next horizontal step is blocked.
- `walk` out 1: horizontal motion permitted this frame.
- `climb` out 1: vertical motion permitted this frame.
- `dir` out 2: 0=left, 1=right, 2=up, 3=down; holds its last value while idle.
- `anim` out 2: sprite animation frame index.
- `state` out 2: 0=IDLE, 1=WALK, 2=CLIMB, 3=FROZEN.

## Operation
- Decoded request `req` is one of: L, R, U, D, NONE.
- Requests are legal as follows:
  - L is legal if `at_floor & ~wall_left`.
  - R is legal if `at_floor & ~wall_right`.
  - U is legal if `at_ladder & ladder_up`.
  - D is legal if `at_ladder & ladder_down`.
- FSM, evaluated every `frame_clk` edge; priority is top to bottom:
  - `freeze`=1: go to FROZEN with walk=climb=0. Stay there while `freeze` is high; go to IDLE on the first frame `freeze` is low.
  - Legal L/R: go to WALK with walk=1, climb=0, dir=L/R.
  - Legal U/D: go to CLIMB with climb=1, walk=0, dir=U/D.
  - Illegal request while in WALK or CLIMB: keep the current state and dir and continue moving, unless the continuation itself is now illegal. The continuation is illegal if the wall in dir is set, or if the ladder in dir has ended. In that case go to IDLE.
  - NONE: go to IDLE with walk=climb=0.
- `walk` and `climb` are never both 1.
- Animation:
  - A 8-bit counter increments each frame in WALK or CLIMB.
  - At `ANIM_PERIOD-1` the counter wraps to 0 and `anim` increments, wrapping 3 to 0.
  - In IDLE and FROZEN, the counter and `anim` hold their values.
  - On any change of dir, the counter and `anim` clear to 0.

## Timing
- All outputs are registered. A keycode change is reflected one `frame_clk` edge later.
- Legality flags are sampled on the same edge as `keycode`.
- Reset values: state=IDLE, walk=0, climb=0, dir=1 (right), anim=0, animation counter=0, turn buffer empty.
- Reset is asynchronous. Asserting it mid-motion clears all outputs immediately, without waiting for an edge.
- First edge after Reset deasserts: the FSM evaluates normally.
- `freeze` asserted together with a legal request: freeze wins.
- A simultaneous wall and a new legal perpendicular request: the new request wins; there is no idle frame.

## Configuration
- Macro `CHEF_TURN_BUFFER_EN` is defined (turn buffer compiled in):
  - An illegal U/D while in WALK, or an illegal L/R while in CLIMB, is stored in a 1-entry buffer with its lifetime counter set to `BUF_FRAMES`.
  - The counter decrements each frame. The entry is discarded when the counter reaches 0, on `freeze`, or on Reset.
  - A new illegal perpendicular request overwrites the entry and reloads the counter.
  - Each frame, a buffered request that has become legal is taken in place of continuation. The block switches state and dir and clears the buffer.
  - If the live key is NONE while the buffer holds a legal request, the buffered request is still executed.
  - A live legal request always beats the buffer, and also clears it.
- Macro not defined:
  - No buffer logic is compiled.
  - Illegal requests behave exactly as described under Operation.

## Test plan
- Reset while in WALK with dir=R: outputs go to walk=0, climb=0, dir=1, anim=0, state=0 without waiting for a clock edge.
- keycode=0x07 with at_floor=1 and wall_right=0, held for 16 frames with ANIM_PERIOD=8: walk=1 from edge 1; anim steps 0→1 at frame 8 and 1→2 at frame 16.
- WALK right, then wall_right=1: state=IDLE and walk=0 on the same edge.
- WALK right, keycode=0x1A with at_ladder=0, then at_ladder=1 and ladder_up=1 three frames later:
  - Buffer defined: CLIMB with dir=2 on that edge.
  - Buffer undefined: stays in WALK.
- Buffered U held for 17 frames with no ladder (BUF_FRAMES=16): the buffer expires; a ladder arriving at frame 17 does not trigger CLIMB.
- freeze=1 together with legal keycode=0x04: state=FROZEN and walk=0. After freeze falls: IDLE, then WALK left one frame later.
